// File: rtl/tl_ul_pkg.sv
// TileLink-UL opcode constants and the sample feeder FSM state encoding.
// Shared by the feeder and anything that needs to decode its bus traffic.
package tl_ul_pkg;

  localparam logic [2:0] GET      = 3'd4;
  localparam logic [2:0] PUT_FULL = 3'd0;
  localparam logic [2:0] ACK      = 3'd0;
  localparam logic [2:0] ACK_DATA = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_WORD_END,
    ST_DONE
  } feeder_state_e;

endpackage

// File: rtl/pwm_sample_feeder.sv
// TL-UL master copying buffer words into the PWM FIFO one byte per Put, bursts gated by pwm_empty_i.
// One transaction outstanding; A fields held while a_ready is low, d_ready only while a response is due.
module pwm_sample_feeder
  import tl_ul_pkg::*;
#(
  parameter int unsigned TL_RS         = 4,
  parameter int unsigned SOURCE_ID     = 0,
  parameter logic [31:0] PWM_FIFO_ADDR = 32'h0000_0004,
  parameter int unsigned BURST_WORDS   = 2
) (
  input  logic             feeder_clock_i,
  input  logic             feeder_resetn_i,
  input  logic [31:0]      cfg_base_i,
  input  logic [15:0]      cfg_len_i,
  input  logic             cfg_loop_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             pwm_empty_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [2:0]       a_opcode,
  output logic [2:0]       a_param,
  output logic [3:0]       a_size,
  output logic [TL_RS-1:0] a_source,
  output logic [31:0]      a_address,
  output logic [3:0]       a_mask,
  output logic [31:0]      a_data,
  output logic             a_corrupt,
  output logic             a_valid,
  input  logic             a_ready,
  input  logic [2:0]       d_opcode,
  input  logic [1:0]       d_param,
  input  logic [3:0]       d_size,
  input  logic [TL_RS-1:0] d_source,
  input  logic             d_denied,
  input  logic [31:0]      d_data,
  input  logic             d_corrupt,
  input  logic             d_valid,
  output logic             d_ready
);

  localparam logic [7:0] BURST_LAST = 8'(BURST_WORDS - 1);

  feeder_state_e state_q;
  logic [31:0]   base_q;
  logic [15:0]   len_q;
  logic          loop_q;
  logic [15:0]   word_ptr_q;
  logic [7:0]    burst_cnt_q;
  logic [1:0]    byte_idx_q;
  logic [31:0]   sample_word_q;
  logic          stop_pend_q;
  logic          err_q;
  logic          zero_done_q;

  logic        d_bad;
  logic        stop_req;
  logic [15:0] ptr_next;
  logic        last_word;
  logic        unused_inputs;

  assign d_bad     = d_denied | d_corrupt;
  assign stop_req  = stop_i | stop_pend_q;
  assign ptr_next  = word_ptr_q + 16'd1;
  assign last_word = (ptr_next == len_q);
  assign unused_inputs = ^{d_opcode, d_param, d_size, d_source, cfg_base_i[1:0]};

  always_ff @(posedge feeder_clock_i) begin
    if (!feeder_resetn_i) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      len_q         <= '0;
      loop_q        <= 1'b0;
      word_ptr_q    <= '0;
      burst_cnt_q   <= '0;
      byte_idx_q    <= '0;
      sample_word_q <= '0;
      stop_pend_q   <= 1'b0;
      err_q         <= 1'b0;
      zero_done_q   <= 1'b0;
    end else begin
      zero_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          stop_pend_q <= 1'b0;
          if (start_i) begin
            err_q <= 1'b0;
            if (cfg_len_i != 16'd0) begin
              base_q     <= {cfg_base_i[31:2], 2'b00};
              len_q      <= cfg_len_i;
              loop_q     <= cfg_loop_i;
              word_ptr_q <= '0;
              state_q    <= ST_ARMED;
            end else begin
              zero_done_q <= 1'b1;
            end
          end
        end
        ST_ARMED: begin
          if (stop_i) begin
            state_q <= ST_DONE;
          end else if (pwm_empty_i) begin
            burst_cnt_q <= '0;
            state_q     <= ST_RD_REQ;
          end
        end
        // A stop seen while a request is pending is deferred until its D beat.
        ST_RD_REQ, ST_WR_REQ: begin
          if (stop_i) stop_pend_q <= 1'b1;
          if (a_ready) state_q <= (state_q == ST_RD_REQ) ? ST_RD_RESP : ST_WR_RESP;
        end
        ST_RD_RESP: begin
          if (d_valid) begin
            if (d_bad) begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else if (stop_req) begin
              state_q <= ST_DONE;
            end else begin
              sample_word_q <= d_data;
              byte_idx_q    <= 2'd0;
              state_q       <= ST_WR_REQ;
            end
          end else if (stop_i) begin
            stop_pend_q <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (d_valid) begin
            if (d_bad) begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else if (stop_req) begin
              state_q <= ST_DONE;
            end else if (byte_idx_q == 2'd3) begin
              state_q <= ST_WORD_END;
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
              state_q    <= ST_WR_REQ;
            end
          end else if (stop_i) begin
            stop_pend_q <= 1'b1;
          end
        end
        ST_WORD_END: begin
          word_ptr_q  <= last_word ? 16'd0 : ptr_next;
          burst_cnt_q <= burst_cnt_q + 8'd1;
          if ((last_word && !loop_q) || stop_req) begin
            state_q <= ST_DONE;
          end else if (burst_cnt_q == BURST_LAST) begin
            state_q <= ST_ARMED;
          end else begin
            state_q <= ST_RD_REQ;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // A fields are pure functions of registered state, so they hold through a_ready stalls.
  always_comb begin
    a_valid   = 1'b0;
    a_opcode  = 3'd0;
    a_param   = 3'd0;
    a_size    = 4'd0;
    a_source  = '0;
    a_address = 32'd0;
    a_mask    = 4'd0;
    a_data    = 32'd0;
    a_corrupt = 1'b0;
    case (state_q)
      ST_RD_REQ: begin
        a_valid   = 1'b1;
        a_opcode  = GET;
        a_size    = 4'd2;
        a_source  = TL_RS'(SOURCE_ID);
        a_address = base_q + {14'd0, word_ptr_q, 2'b00};
        a_mask    = 4'hF;
      end
      ST_WR_REQ: begin
        a_valid   = 1'b1;
        a_opcode  = PUT_FULL;
        a_size    = 4'd2;
        a_source  = TL_RS'(SOURCE_ID);
        a_address = PWM_FIFO_ADDR;
        a_mask    = 4'hF;
        a_data    = {24'h0, sample_word_q[{byte_idx_q, 3'b000} +: 8]};
      end
      default: begin
      end
    endcase
  end

  assign d_ready = (state_q == ST_RD_RESP) || (state_q == ST_WR_RESP);
  assign busy_o  = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o  = (state_q == ST_DONE) || zero_done_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Bench for pwm_sample_feeder: memory-backed TL-UL slave, transaction log, and a
// high-level model that lists the Get/Put sequence a buffer should produce.
module tb_pwm_sample_feeder;
  import tl_ul_pkg::*;

  localparam logic [31:0] FIFO_ADDR = 32'h0000_0004;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic [31:0] base;
    logic [15:0] len;
    int          exp_gets;
    int          exp_puts;
    int          exp_done;
    logic        exp_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] cfg_base;
  logic [15:0] cfg_len;
  logic        cfg_loop;
  logic        start_pulse, stop_pulse, pwm_empty;
  logic        busy, done, err;
  logic [2:0]  a_opcode, a_param;
  logic [3:0]  a_size, a_mask;
  logic [3:0]  a_source;
  logic [31:0] a_address, a_data;
  logic        a_corrupt, a_valid, a_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic [3:0]  d_source;
  logic        d_denied, d_corrupt, d_valid, d_ready;
  logic [31:0] d_data;
  logic [82:0] a_vec;

  int   n_checks = 0;
  int   n_errs = 0;
  int   done_cnt = 0;
  int   hold_mismatch = 0;
  int   stall_seen = 0;
  int   stall_puts = 0;
  bit   deny_get = 1'b0;
  bit   rand_ready = 1'b0;
  txn_t log_q[$];
  txn_t exp_q[$];
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  assign a_vec = {a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt};

  pwm_sample_feeder #(
    .TL_RS(4), .SOURCE_ID(0), .PWM_FIFO_ADDR(FIFO_ADDR), .BURST_WORDS(2)
  ) dut (
    .feeder_clock_i(clk), .feeder_resetn_i(resetn),
    .cfg_base_i(cfg_base), .cfg_len_i(cfg_len), .cfg_loop_i(cfg_loop),
    .start_i(start_pulse), .stop_i(stop_pulse), .pwm_empty_i(pwm_empty),
    .busy_o(busy), .done_o(done), .err_o(err),
    .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt),
    .a_valid(a_valid), .a_ready(a_ready),
    .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_source(d_source),
    .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt), .d_valid(d_valid),
    .d_ready(d_ready)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  function automatic int count_op(input logic [2:0] op);
    int n = 0;
    foreach (log_q[k]) if (log_q[k].op == op) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: word k of a run reads base + 4*(k mod len) and yields four byte Puts, LSB first.
  task automatic build_model(input logic [31:0] base, input int len, input bit loop, input int n_words);
    logic [31:0] a, w;
    exp_q.delete();
    for (int k = 0; k < n_words; k++) begin
      a = {base[31:2], 2'b00} + 32'(4 * (loop ? k % len : k));
      w = mem_rd(a);
      exp_q.push_back('{GET, a, 32'h0});
      for (int b = 0; b < 4; b++)
        exp_q.push_back('{PUT_FULL, FIFO_ADDR, (w >> (8 * b)) & 32'hFF});
    end
  endtask

  task automatic compare_log(input string name);
    int bad = -1;
    check({name, " log length"}, log_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++)
      if (bad < 0 && (log_q[k].op !== exp_q[k].op || log_q[k].addr !== exp_q[k].addr ||
                      (exp_q[k].op == PUT_FULL && log_q[k].data !== exp_q[k].data)))
        bad = k;
    check({name, " first bad log index"}, bad, -1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_run(input logic [31:0] base, input logic [15:0] len, input logic loop);
    @(negedge clk);
    cfg_base = base; cfg_len = len; cfg_loop = loop; start_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input bit rand_empty);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        if (rand_empty) pwm_empty = 1'($urandom_range(0, 1));
      end
    end
    check({name, " done seen"}, seen, 1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
    end
  end

  // TL-UL slave: responds the cycle after each A handshake and logs every request.
  initial begin : slave
    logic [82:0] prev_vec;
    bit   prev_stall, a_fire, d_fire;
    txn_t last;
    prev_stall = 1'b0; a_fire = 1'b0; d_fire = 1'b0; prev_vec = '0;
    last = '{3'd0, 32'd0, 32'd0};
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_stall = 1'b0; a_fire = 1'b0; d_fire = 1'b0;
        a_ready = 1'b0; d_valid = 1'b0; d_denied = 1'b0; d_opcode = 3'd0; d_data = 32'd0;
      end else begin
        if (d_fire) begin
          d_valid = 1'b0; d_denied = 1'b0; d_opcode = 3'd0; d_data = 32'd0;
        end
        if (a_fire) begin
          d_valid = 1'b1;
          if (last.op == GET) begin
            d_opcode = ACK_DATA; d_data = mem_rd(last.addr);
            d_denied = deny_get; deny_get = 1'b0;
          end else begin
            d_opcode = ACK; d_data = 32'd0;
          end
        end
        if (prev_stall && (!a_valid || a_vec !== prev_vec)) hold_mismatch++;
        if (a_valid && a_opcode == PUT_FULL && stall_puts > 0) begin
          a_ready = 1'b0; stall_puts--; stall_seen++;
        end else if (rand_ready) a_ready = ($urandom_range(0, 2) != 0);
        else a_ready = 1'b1;
        prev_stall = a_valid && !a_ready;
        prev_vec   = a_vec;
        a_fire     = a_valid && a_ready;
        if (a_fire) begin
          last = '{a_opcode, a_address, a_data};
          log_q.push_back(last);
        end
        d_fire = d_valid && d_ready;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    logic [7:0] exp_bytes[4];
    int   d0;
    bit   seen, busy_drop;

    resetn = 1'b0; cfg_base = '0; cfg_len = '0; cfg_loop = 1'b0;
    start_pulse = 1'b0; stop_pulse = 1'b0; pwm_empty = 1'b0;
    a_ready = 1'b0; d_opcode = '0; d_param = '0; d_size = 4'd2; d_source = '0;
    d_denied = 1'b0; d_data = '0; d_corrupt = 1'b0; d_valid = 1'b0;
    exp_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    vecs[0] = '{32'h0000_1000, 16'd1, 1, 4, 1, 1'b1};
    vecs[1] = '{32'h0000_2003, 16'd2, 2, 8, 1, 1'b1};
    vecs[2] = '{32'h0000_3000, 16'd0, 0, 0, 1, 1'b0};
    vecs[3] = '{32'hFFFF_FFF8, 16'd3, 3, 12, 1, 1'b1};
    vecs[4] = '{32'h0000_4000, 16'd5, 5, 20, 1, 1'b1};
    mem[32'h0000_1000] = 32'hDDCCBBAA;

    idle(3);
    check("reset a_valid", a_valid, 0);
    check("reset d_ready", d_ready, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset A fields", {a_opcode, a_size, a_mask, a_address, a_data}, 0);
    resetn = 1'b1;
    idle(2);

    for (int i = 0; i < 5; i++) begin
      log_q.delete(); d0 = done_cnt; pwm_empty = 1'b1;
      start_run(vecs[i].base, vecs[i].len, 1'b0);
      check($sformatf("vec%0d busy after start", i), busy, vecs[i].exp_busy);
      wait_done($sformatf("vec%0d", i), 2000, 1'b0);
      idle(3);
      check($sformatf("vec%0d done pulses", i), done_cnt - d0, vecs[i].exp_done);
      check($sformatf("vec%0d gets", i), count_op(GET), vecs[i].exp_gets);
      check($sformatf("vec%0d puts", i), count_op(PUT_FULL), vecs[i].exp_puts);
      check($sformatf("vec%0d busy at end", i), busy, 0);
      build_model(vecs[i].base, int'(vecs[i].len), 1'b0, int'(vecs[i].len));
      compare_log($sformatf("vec%0d", i));
      if (i == 0)
        for (int b = 0; b < 4; b++)
          check($sformatf("vec0 put byte %0d", b), log_q[1 + b].data, {24'h0, exp_bytes[b]});
    end

    // Random buffers with random a_ready and a flickering empty interrupt.
    rand_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      logic [31:0] rb;
      int rl;
      rb = $urandom; rl = $urandom_range(1, 6);
      log_q.delete();
      start_run(rb, 16'(rl), 1'b0);
      wait_done($sformatf("rand%0d", r), 5000, 1'b1);
      pwm_empty = 1'b1;
      idle(3);
      build_model(rb, rl, 1'b0, rl);
      compare_log($sformatf("rand%0d", r));
    end
    rand_ready = 1'b0;

    // Looping buffer: bursts of two words, each burst gated by the empty interrupt.
    log_q.delete(); pwm_empty = 1'b1; busy_drop = 1'b0;
    start_run(32'h0000_5000, 16'd3, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (log_q.size() >= 1) seen = 1'b1;
    end
    pwm_empty = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!busy) busy_drop = 1'b1;
    end
    check("loop gets after burst 1", count_op(GET), 2);
    check("loop puts after burst 1", count_op(PUT_FULL), 8);
    pwm_empty = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk);
      if (!busy) busy_drop = 1'b1;
      if (count_op(GET) >= 5) seen = 1'b1;
    end
    pwm_empty = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy) busy_drop = 1'b1;
    end
    check("loop busy never dropped", busy_drop, 0);
    build_model(32'h0000_5000, 3, 1'b1, 6);
    compare_log("loop");
    d0 = done_cnt;
    @(negedge clk); stop_pulse = 1'b1;
    @(negedge clk); stop_pulse = 1'b0;
    wait_done("loop stop in ARMED", 5, 1'b0);
    idle(10);
    check("loop stop done pulses", done_cnt - d0, 1);
    check("loop no request after stop", log_q.size(), 30);

    // Put stalled by a_ready for five cycles.
    log_q.delete(); pwm_empty = 1'b1; stall_seen = 0; stall_puts = 5;
    start_run(32'h0000_6000, 16'd1, 1'b0);
    wait_done("stall", 500, 1'b0);
    idle(3);
    check("stall cycles", stall_seen, 5);
    check("stall puts", count_op(PUT_FULL), 4);
    build_model(32'h0000_6000, 1, 1'b0, 1);
    compare_log("stall");

    // Denied Get response.
    log_q.delete(); d0 = done_cnt; deny_get = 1'b1;
    start_run(32'h0000_7000, 16'd2, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (err) seen = 1'b1;
    end
    idle(3);
    check("deny err", err, 1);
    check("deny busy", busy, 0);
    check("deny gets", count_op(GET), 1);
    check("deny puts", count_op(PUT_FULL), 0);
    check("deny done pulses", done_cnt - d0, 0);
    start_run(32'h0000_7100, 16'd1, 1'b0);
    check("err cleared by start", err, 0);
    wait_done("after deny", 500, 1'b0);
    idle(3);

    // Stop while a Put is held off by a_ready.
    log_q.delete(); d0 = done_cnt; stall_puts = 8;
    start_run(32'h0000_8000, 16'd2, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (a_valid && a_opcode == PUT_FULL) seen = 1'b1;
    end
    check("stop: stalled put seen", seen, 1);
    stop_pulse = 1'b1;
    @(negedge clk); stop_pulse = 1'b0;
    wait_done("stop in WR_REQ", 100, 1'b0);
    idle(20);
    stall_puts = 0;
    check("stop gets", count_op(GET), 1);
    check("stop puts", count_op(PUT_FULL), 1);
    check("stop done pulses", done_cnt - d0, 1);
    check("stop a_valid quiet", a_valid, 0);
    check("stop ack consumed", d_valid, 0);

    // Reset while waiting for a Put acknowledge.
    log_q.delete();
    start_run(32'h0000_9000, 16'd1, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (d_ready && log_q.size() >= 2) seen = 1'b1;
    end
    check("reset test reached WR_RESP", seen, 1);
    resetn = 1'b0;
    @(negedge clk);
    check("mid reset a_valid", a_valid, 0);
    check("mid reset d_ready", d_ready, 0);
    check("mid reset busy", busy, 0);
    check("mid reset err", err, 0);
    resetn = 1'b1;
    idle(3);

    check("A fields stable under stall", hold_mismatch, 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_sample_feeder.md
Name: pwm_sample_feeder

Overview:
- TileLink-UL master that streams 8-bit PWM samples from a circular buffer in memory into the PWM sample FIFO.
- Sits between the system crossbar and the PWM peripheral.
- Refills are triggered by the PWM empty interrupt. Each refill moves a bounded burst of samples.
- Replaces CPU interrupt servicing for audio and waveform playback.

Parameters:
- TL_RS, 4, width of the TileLink source field.
- SOURCE_ID, 0, source value driven on every A-channel request.
- PWM_FIFO_ADDR, 32'h0000_0004, byte address of the PWM sample FIFO register.
- BURST_WORDS, 2, words fetched per trigger (4 samples per word, so 8 samples fill the FIFO).

Ports:
- feeder_clock_i  in  1  single clock.
- feeder_resetn_i  in  1  synchronous, active-low reset.
- cfg_base_i  in  32  word-aligned buffer base address; bits [1:0] are ignored.
- cfg_len_i  in  16  buffer length in 32-bit words; 0 means no transfer.
- cfg_loop_i  in  1  1 = wrap to base at end of buffer; 0 = stop.
- start_i  in  1  1-cycle pulse: latch the cfg inputs and arm.
- stop_i  in  1  1-cycle pulse: abort after the current TL beat completes.
- pwm_empty_i  in  1  PWM empty interrupt (level).
- busy_o  out  1  high from armed until done or error.
- done_o  out  1  1-cycle pulse when a non-loop buffer is exhausted or a stop completes.
- err_o  out  1  sticky; set on denied or corrupt D response; cleared by start_i.
- a_opcode/a_param/a_size/a_source/a_address/a_mask/a_data/a_corrupt/a_valid  out  3/3/4/TL_RS/32/4/32/1/1  TL-UL A channel.
- a_ready  in  1
- d_opcode/d_param/d_size/d_source/d_denied/d_data/d_corrupt/d_valid  in  3/2/4/TL_RS/1/32/1/1  TL-UL D channel.
- d_ready  out  1

Behaviour:
- Reset (feeder_resetn_i=0 at a clock edge):
  - state IDLE; a_valid=0, d_ready=0, busy_o=0, done_o=0, err_o=0.
  - All counters 0. Other A fields 0.
- States and transitions:
  - IDLE: start_i with cfg_len_i!=0 → ARMED; latch base/len/loop, set word_ptr=0, err_o=0.
  - IDLE: start_i with cfg_len_i==0 → done_o pulse, stay IDLE.
  - ARMED: pwm_empty_i=1 → RD_REQ; burst_cnt=0.
  - RD_REQ: a_valid=1, opcode Get(4), size 2, mask 4'hF, address base+4*word_ptr. Leave when a_valid&a_ready → RD_RESP.
  - RD_RESP: d_ready=1. On d_valid, capture d_data into sample_word; byte_idx=0 → WR_REQ.
  - WR_REQ: PutFullData(0), size 2, mask 4'hF, address PWM_FIFO_ADDR, a_data={24'h0, sample_word[8*byte_idx+:8]}. Leave when a_valid&a_ready → WR_RESP.
  - WR_RESP: on d_valid, if byte_idx==3 → WORD_END, else byte_idx+1 → WR_REQ.
  - WORD_END:
    - word_ptr+1; at len it wraps to 0 if loop, else → DONE.
    - burst_cnt+1; when it reaches BURST_WORDS → ARMED, else → RD_REQ.
  - DONE: done_o=1 for one cycle → IDLE.
- Order and outstanding requests: bytes are written little-endian (byte 0 first). At most one transaction is outstanding.
- A-channel hold: A fields stay stable while a_valid=1 and a_ready=0. a_valid never drops before the handshake.
- D-channel response:
  - d_ready=1 only in RD_RESP and WR_RESP.
  - On d_denied or d_corrupt: err_o=1, and the state goes to IDLE with no done_o pulse.
  - d_source is not checked.
- stop_i:
  - In ARMED: go to DONE immediately.
  - In RD_REQ/WR_REQ: honoured only after the pending handshake and its D response (a_valid must not drop). Then go to DONE.
  - In RESP states: go to DONE after the D beat.
  - stop_i together with start_i in IDLE: start wins.
- Triggering: pwm_empty_i is sampled only in ARMED. If still high after a burst, the next burst starts the cycle after re-entering ARMED.
- Address arithmetic: addresses are computed mod 2^32; word_ptr is 16-bit.
- start_i while busy is ignored.
- Reset mid-transaction: bus state is abandoned (the crossbar is reset by the same reset).

Decomposition:
- Shared package tl_ul_pkg: opcode constants (GET=4, PUT_FULL=0, ACK=0, ACK_DATA=1) and an FSM state enum typedef.
- No sub-module; single FSM with counters.

Test Plan:
- len=1, loop=0, memory word 32'hDDCCBBAA, pwm_empty_i=1: one Get at base, then 4 Puts at PWM_FIFO_ADDR with data 0xAA, 0xBB, 0xCC, 0xDD in order; done_o pulses; busy_o falls.
- len=3, loop=1, BURST_WORDS=2, empty held high:
  - Get addresses cycle base, +4, +8, base, +4…
  - Between bursts there is a return to ARMED.
  - busy_o stays 1.
- a_ready held low 5 cycles during a Put: a_valid and all A fields remain constant; exactly one Put is issued.
- d_denied=1 on the Get response: err_o=1, no Puts issued, state IDLE, no done_o. A following start_i clears err_o.
- stop_i pulsed during WR_REQ with a_ready low: Put completes, its AckD is consumed, done_o pulses, and no further requests follow.
- Reset asserted low in WR_RESP: next cycle a_valid=0, d_ready=0, busy_o=0, err_o=0.
